// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP datapath helper blocks: depth limits,
// default widths and a width helper that never returns zero.
package dsp_pkg;

    localparam int MAX_PIPE_DEPTH = 16;
    localparam int DEFAULT_WIDTH  = 18;

    // Bits needed to hold values 0..n-1, but never fewer than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register of the pipeline chain. clear drops the valid bit
// only; data keeps its value so a flushed stage costs no data-path toggling.
module pipe_stage #(
    parameter int WIDTH    = 18,
    parameter int DATA_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= d_valid;
        end
    end

    generate
        if (DATA_RST != 0) begin : g_data_rst
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (load && !clear) begin
                    data_reg <= d_data;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (load && !clear) begin
                    data_reg <= d_data;
                end
            end
        end
    endgenerate

    assign q_valid = valid_reg;
    assign q_data  = data_reg;

endmodule

// File: rtl/reg_pipe_chain.sv
// DEPTH-stage ready/valid register chain with bubble collapse, clock-enable
// freeze, flush and an occupancy count. DEPTH=0 is a pure wire bypass.
module reg_pipe_chain
    import dsp_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = 2,
    parameter int DATA_RST = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ce,
    input  logic                               flush,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [clog2_min1(DEPTH+1)-1:0]     count
);

    localparam int CW = clog2_min1(DEPTH + 1);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_data  = in_data;
            assign out_valid = in_valid && ce;
            assign in_ready  = out_ready && ce;
            assign count     = '0;
        end else begin : g_pipe
            logic [DEPTH:0]   adv;
            logic [DEPTH-1:0] stage_valid;
            logic [WIDTH-1:0] stage_data [DEPTH];
            logic [CW-1:0]    count_reg;
            logic [CW-1:0]    count_next;
            logic             in_xfer;
            logic             out_xfer;

            // Ready ripples back from the output; an empty stage always
            // accepts, which is what collapses bubbles under backpressure.
            always_comb begin
                adv        = '0;
                adv[DEPTH] = out_ready;
                for (int s = DEPTH - 1; s >= 0; s--) begin
                    adv[s] = !stage_valid[s] || adv[s+1];
                end
            end

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic             src_valid;
                logic [WIDTH-1:0] src_data;

                if (gi == 0) begin : g_head
                    assign src_valid = in_valid;
                    assign src_data  = in_data;
                end else begin : g_body
                    assign src_valid = stage_valid[gi-1];
                    assign src_data  = stage_data[gi-1];
                end

                pipe_stage #(
                    .WIDTH    (WIDTH),
                    .DATA_RST (DATA_RST)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .load    (ce && adv[gi]),
                    .clear   (flush),
                    .d_valid (src_valid),
                    .d_data  (src_data),
                    .q_valid (stage_valid[gi]),
                    .q_data  (stage_data[gi])
                );
            end

            assign in_ready  = ce && !flush && adv[0];
            assign out_valid = ce && stage_valid[DEPTH-1];
            assign out_data  = stage_data[DEPTH-1];
            assign in_xfer   = in_valid && in_ready;
            assign out_xfer  = out_valid && out_ready;

            // Tracked incrementally so it always equals the popcount of
            // stage_valid after the same edge.
            always_comb begin
                count_next = count_reg;
                if (flush) begin
                    count_next = '0;
                end else if (in_xfer && !out_xfer) begin
                    count_next = count_reg + CW'(1);
                end else if (out_xfer && !in_xfer) begin
                    count_next = count_reg - CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign count = count_reg;
        end
    endgenerate

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Bench for reg_pipe_chain: four instances (DEPTH 0,2,3,4) driven one at a
// time, with a queue scoreboard on the active instance's output transfers.
module tb_reg_pipe_chain;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ce_s        [4];
    logic        flush_s     [4];
    logic        in_valid_s  [4];
    logic        in_ready_s  [4];
    logic        out_valid_s [4];
    logic        out_ready_s [4];
    logic [17:0] in_data_s   [4];
    logic [17:0] out_data_s  [4];
    logic [4:0]  cnt_s       [4];

    int          checks = 0;
    int          errors = 0;
    int          act    = 0;
    logic [17:0] sb_q [$];

    // Instance gi has DEPTH 0,2,3,4 for gi = 0,1,2,3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int D  = (gi == 0) ? 0 : gi + 1;
        localparam int CW = dsp_pkg::clog2_min1(D + 1);
        logic [CW-1:0] c;

        reg_pipe_chain #(.WIDTH(18), .DEPTH(D), .DATA_RST(1)) dut (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce_s[gi]),
            .flush     (flush_s[gi]),
            .in_data   (in_data_s[gi]),
            .in_valid  (in_valid_s[gi]),
            .in_ready  (in_ready_s[gi]),
            .out_data  (out_data_s[gi]),
            .out_valid (out_valid_s[gi]),
            .out_ready (out_ready_s[gi]),
            .count     (c)
        );
        assign cnt_s[gi] = 5'(c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle and scoreboard the transfers happening at the next edge.
    task automatic sample();
        logic [17:0] exp_d;
        @(negedge clk);
        if (in_valid_s[act] && in_ready_s[act]) sb_q.push_back(in_data_s[act]);
        if (out_valid_s[act] && out_ready_s[act]) begin
            checks++;
            $display("inst%0d out transfer data=%h", act, out_data_s[act]);
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected inst%0d: got out_data=%h, expected no output", act, out_data_s[act]);
            end else begin
                exp_d = sb_q.pop_front();
                if (out_data_s[act] !== exp_d) begin
                    errors++;
                    $display("FAIL sb_data inst%0d: got %h, expected %h", act, out_data_s[act], exp_d);
                end
            end
        end
        if (rst || flush_s[act]) sb_q.delete();
    endtask

    task automatic test_reset();
        int lat;
        act = 2;
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        sample();
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid_s[i] !== 1'b0 || cnt_s[i] !== 5'd0 || in_ready_s[i] !== 1'b1 || out_data_s[i] !== 18'h0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got ov=%b cnt=%0d ir=%b od=%h, expected 0 0 1 0",
                         i, out_valid_s[i], cnt_s[i], in_ready_s[i], out_data_s[i]);
            end
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid_s[2] = 1'b1; in_data_s[2] = 18'(17 * (i + 1));
            sample(); tick();
        end
        in_valid_s[2] = 1'b0;
        sample();
        checks++;
        if (cnt_s[2] !== 5'd3 || out_valid_s[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: got cnt=%0d ov=%b, expected 3 1", cnt_s[2], out_valid_s[2]);
        end
        tick();
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        sample();
        checks++;
        if (out_valid_s[2] !== 1'b0 || cnt_s[2] !== 5'd0 || out_data_s[2] !== 18'h0) begin
            errors++;
            $display("FAIL reset_midstream: got ov=%b cnt=%0d od=%h, expected 0 0 0",
                     out_valid_s[2], cnt_s[2], out_data_s[2]);
        end
        tick();
        in_data_s[2] = 18'h155; in_valid_s[2] = 1'b1; out_ready_s[2] = 1'b1;
        sample();
        checks++;
        if (in_ready_s[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_accept: got in_ready=%b, expected 1", in_ready_s[2]);
        end
        tick();
        in_valid_s[2] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            sample();
            if (out_valid_s[2] && lat < 0) lat = k;
            tick();
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL reset_latency: got %0d cycles, expected 3", lat);
        end
        out_ready_s[2] = 1'b0;
    endtask

    task automatic test_streaming();
        logic exp_v;
        act = 1; out_ready_s[1] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid_s[1] = (c < 5);
            in_data_s[1]  = 18'(c + 1);
            sample();
            exp_v = (c >= 2 && c <= 6);
            checks++;
            if (out_valid_s[1] !== exp_v) begin
                errors++;
                $display("FAIL stream_valid c=%0d: got %b, expected %b", c, out_valid_s[1], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_data_s[1] !== 18'(c - 1)) begin
                    errors++;
                    $display("FAIL stream_data c=%0d: got %h, expected %h", c, out_data_s[1], 18'(c - 1));
                end
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (cnt_s[1] !== 5'd2) begin
                    errors++;
                    $display("FAIL stream_count c=%0d: got %0d, expected 2", c, cnt_s[1]);
                end
            end
            tick();
        end
        in_valid_s[1] = 1'b0; out_ready_s[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        act = 2; out_ready_s[2] = 1'b0;
        in_valid_s[2] = 1'b1; in_data_s[2] = 18'hA; sample();
        checks++;
        if (in_ready_s[2] !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b, expected 1", in_ready_s[2]); end
        tick();
        in_valid_s[2] = 1'b0; sample(); tick();
        in_valid_s[2] = 1'b1; in_data_s[2] = 18'hB; sample();
        checks++;
        if (in_ready_s[2] !== 1'b1) begin errors++; $display("FAIL bp_ready_b: got %b, expected 1", in_ready_s[2]); end
        tick();
        in_valid_s[2] = 1'b0; sample();
        checks++;
        if (cnt_s[2] !== 5'd2 || in_ready_s[2] !== 1'b1) begin
            errors++;
            $display("FAIL bp_collapse: got cnt=%0d ir=%b, expected 2 1", cnt_s[2], in_ready_s[2]);
        end
        tick();
        in_valid_s[2] = 1'b1; in_data_s[2] = 18'hC; sample();
        checks++;
        if (in_ready_s[2] !== 1'b1 || cnt_s[2] !== 5'd2) begin
            errors++;
            $display("FAIL bp_ready_c: got ir=%b cnt=%0d, expected 1 2", in_ready_s[2], cnt_s[2]);
        end
        tick();
        in_data_s[2] = 18'hD;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++;
            if (in_ready_s[2] !== 1'b0 || cnt_s[2] !== 5'd3 || out_valid_s[2] !== 1'b1 || out_data_s[2] !== 18'hA) begin
                errors++;
                $display("FAIL bp_full k=%0d: got ir=%b cnt=%0d ov=%b od=%h, expected 0 3 1 00a",
                         k, in_ready_s[2], cnt_s[2], out_valid_s[2], out_data_s[2]);
            end
            tick();
        end
        in_valid_s[2] = 1'b0; out_ready_s[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin sample(); tick(); end
        checks++;
        if (sb_q.size() != 0 || cnt_s[2] !== 5'd0) begin
            errors++;
            $display("FAIL bp_drain: got pending=%0d cnt=%0d, expected 0 0", sb_q.size(), cnt_s[2]);
        end
        out_ready_s[2] = 1'b0;
    endtask

    task automatic test_ce_freeze();
        act = 1; out_ready_s[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_s[1] = 1'b1; in_data_s[1] = 18'(33 + i);
            sample(); tick();
        end
        ce_s[1] = 1'b0; in_valid_s[1] = 1'b1; in_data_s[1] = 18'h99; out_ready_s[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (in_ready_s[1] !== 1'b0 || out_valid_s[1] !== 1'b0 || cnt_s[1] !== 5'd2) begin
                errors++;
                $display("FAIL ce_freeze k=%0d: got ir=%b ov=%b cnt=%0d, expected 0 0 2",
                         k, in_ready_s[1], out_valid_s[1], cnt_s[1]);
            end
            tick();
        end
        ce_s[1] = 1'b1; in_valid_s[1] = 1'b0;
        sample();
        checks++;
        if (out_valid_s[1] !== 1'b1 || out_data_s[1] !== 18'h21) begin
            errors++;
            $display("FAIL ce_resume: got ov=%b od=%h, expected 1 021", out_valid_s[1], out_data_s[1]);
        end
        tick();
        for (int k = 0; k < 3; k++) begin sample(); tick(); end
        checks++;
        if (sb_q.size() != 0 || cnt_s[1] !== 5'd0) begin
            errors++;
            $display("FAIL ce_drain: got pending=%0d cnt=%0d, expected 0 0", sb_q.size(), cnt_s[1]);
        end
        out_ready_s[1] = 1'b0;
    endtask

    task automatic test_flush();
        act = 3; out_ready_s[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_s[3] = 1'b1; in_data_s[3] = 18'(65 + i);
            sample(); tick();
        end
        in_valid_s[3] = 1'b0; sample();
        checks++;
        if (cnt_s[3] !== 5'd4 || in_ready_s[3] !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got cnt=%0d ir=%b, expected 4 0", cnt_s[3], in_ready_s[3]);
        end
        tick();
        flush_s[3] = 1'b1; in_valid_s[3] = 1'b1; in_data_s[3] = 18'h77; out_ready_s[3] = 1'b1;
        sample();
        checks++;
        if (in_ready_s[3] !== 1'b0 || out_valid_s[3] !== 1'b1 || out_data_s[3] !== 18'h41) begin
            errors++;
            $display("FAIL flush_cycle: got ir=%b ov=%b od=%h, expected 0 1 041",
                     in_ready_s[3], out_valid_s[3], out_data_s[3]);
        end
        tick();
        flush_s[3] = 1'b0; in_valid_s[3] = 1'b0;
        sample();
        checks++;
        if (cnt_s[3] !== 5'd0 || out_valid_s[3] !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got cnt=%0d ov=%b, expected 0 0", cnt_s[3], out_valid_s[3]);
        end
        tick();
        for (int k = 0; k < 5; k++) begin sample(); tick(); end
        out_ready_s[3] = 1'b0;
    endtask

    task automatic test_bypass();
        act = 0; in_data_s[0] = 18'h3FFFF; in_valid_s[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_ready_s[0] = (i % 2 == 1);
            sample();
            checks++;
            if (in_ready_s[0] !== out_ready_s[0] || out_valid_s[0] !== 1'b1 ||
                out_data_s[0] !== 18'h3FFFF || cnt_s[0] !== 5'd0) begin
                errors++;
                $display("FAIL bypass i=%0d: got ir=%b ov=%b od=%h cnt=%0d, expected ir=%b 1 3ffff 0",
                         i, in_ready_s[0], out_valid_s[0], out_data_s[0], cnt_s[0], out_ready_s[0]);
            end
            tick();
        end
        ce_s[0] = 1'b0; out_ready_s[0] = 1'b1;
        sample();
        checks++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_ce: got ov=%b ir=%b, expected 0 0", out_valid_s[0], in_ready_s[0]);
        end
        tick();
        ce_s[0] = 1'b1; in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ce_s[i] = 1'b1; flush_s[i] = 1'b0; in_valid_s[i] = 1'b0;
            out_ready_s[i] = 1'b0; in_data_s[i] = '0;
        end
        test_reset();
        test_streaming();
        test_backpressure();
        test_ce_freeze();
        test_flush();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
